// File: rtl/free_list_pkg.sv
// Shared rename-stage sizing (physical/architectural register counts, tag type)
// used by free_list and map_table.
package free_list_pkg;

    localparam int DEF_N         = 3;
    localparam int DEF_PHYS_REGS = 64;
    localparam int DEF_ARCH_REGS = 32;
    localparam int DEF_FL_SIZE   = DEF_PHYS_REGS - DEF_ARCH_REGS;
    localparam int DEF_TAG_W     = $clog2(DEF_PHYS_REGS);

    typedef logic [DEF_TAG_W-1:0] phys_tag_t;

    // Where the allocation head goes next cycle.
    typedef enum logic [1:0] {
        HEAD_HOLD    = 2'd0,
        HEAD_ADVANCE = 2'd1,
        HEAD_RECOVER = 2'd2
    } head_sel_e;

endpackage

// File: rtl/free_list_prefix_count.sv
// Exclusive prefix popcount: prefix_o[i] is the number of set bits below bit i,
// total_o the number of set bits overall.
module prefix_count
    import free_list_pkg::*;
#(
    parameter int  N  = DEF_N,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]         bits_i,
    output logic [N-1:0][CW-1:0] prefix_o,
    output logic [CW-1:0]        total_o
);

    logic [CW-1:0] acc;

    always_comb begin
        acc      = '0;
        prefix_o = '0;
        for (int i = 0; i < N; i++) begin
            prefix_o[i] = acc;
            acc         = acc + CW'(bits_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical register tags: compacted multi-slot allocation
// at the head, retirement frees at the tail, single-cycle mispredict rollback.
module free_list
    import free_list_pkg::*;
#(
    parameter int  N         = DEF_N,
    parameter int  PHYS_REGS = DEF_PHYS_REGS,
    parameter int  ARCH_REGS = DEF_ARCH_REGS,
    parameter int  FL_SIZE   = PHYS_REGS - ARCH_REGS,
    localparam int TAG_W     = $clog2(PHYS_REGS),
    localparam int CNT_W     = $clog2(FL_SIZE + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N-1:0]            alloc_reqs,
    output logic [N-1:0][TAG_W-1:0] alloc_tags,
    output logic                    alloc_stall,
    output logic [CNT_W-1:0]        free_count,
    input  logic [N-1:0]            free_valids,
    input  logic [N-1:0][TAG_W-1:0] free_tags,
    input  logic                    mispredict
);

    localparam int PTR_W = $clog2(FL_SIZE);
    localparam int KW    = $clog2(N + 1);

    logic [FL_SIZE-1:0][TAG_W-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]              head_q, head_d;
    logic [PTR_W-1:0]              tail_q, tail_d;
    logic [PTR_W-1:0]              arch_head_q, arch_head_d;
    logic [CNT_W-1:0]              count_q, count_d;

    logic [N-1:0][KW-1:0]          alloc_prefix, free_prefix;
    logic [KW-1:0]                 alloc_total, free_total;
    logic [N-1:0][PTR_W-1:0]       alloc_idx, free_idx;
    logic                          grant;
    head_sel_e                     head_sel;

    // Offsets never exceed N <= FL_SIZE, so a single conditional subtract wraps.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input logic [PTR_W:0]   off);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= (PTR_W+1)'(FL_SIZE))
            sum = sum - (PTR_W+1)'(FL_SIZE);
        return sum[PTR_W-1:0];
    endfunction

    prefix_count #(.N(N)) u_alloc_prefix (
        .bits_i   (alloc_reqs),
        .prefix_o (alloc_prefix),
        .total_o  (alloc_total)
    );

    prefix_count #(.N(N)) u_free_prefix (
        .bits_i   (free_valids),
        .prefix_o (free_prefix),
        .total_o  (free_total)
    );

    assign free_count  = count_q;
    assign alloc_stall = CNT_W'(alloc_total) > count_q;
    assign grant       = !alloc_stall && !mispredict;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            alloc_idx[i]  = wrap_add(head_q, (PTR_W+1)'(alloc_prefix[i]));
            free_idx[i]   = wrap_add(tail_q, (PTR_W+1)'(free_prefix[i]));
            alloc_tags[i] = entries_q[alloc_idx[i]];
        end
    end

    // Frees land at the tail in slot order; they are never visible to the
    // allocation lookup until the following cycle.
    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < N; i++) begin
            if (free_valids[i])
                entries_d[free_idx[i]] = free_tags[i];
        end
    end

    always_comb begin
        tail_d      = wrap_add(tail_q, (PTR_W+1)'(free_total));
        arch_head_d = wrap_add(arch_head_q, (PTR_W+1)'(free_total));

        head_sel = HEAD_HOLD;
        if (mispredict)
            head_sel = HEAD_RECOVER;
        else if (!alloc_stall)
            head_sel = HEAD_ADVANCE;

        // Recovery includes same-cycle retires, so it targets the updated arch head.
        case (head_sel)
            HEAD_ADVANCE: head_d = wrap_add(head_q, (PTR_W+1)'(alloc_total));
            HEAD_RECOVER: head_d = arch_head_d;
            default:      head_d = head_q;
        endcase

        if (mispredict)
            count_d = CNT_W'(FL_SIZE);
        else
            count_d = count_q - (grant ? CNT_W'(alloc_total) : CNT_W'(0))
                              + CNT_W'(free_total);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            arch_head_q <= '0;
            count_q     <= CNT_W'(FL_SIZE);
            for (int e = 0; e < FL_SIZE; e++)
                entries_q[e] <= TAG_W'(ARCH_REGS + e);
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            arch_head_q <= arch_head_d;
            count_q     <= count_d;
            entries_q   <= entries_d;
        end
    end

    // A full list has nothing in flight, so a retire free would overflow it.
    always_ff @(posedge clock) begin
        if (!reset)
            assert (!((|free_valids) && (count_q == CNT_W'(FL_SIZE))));
    end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed vector table, hand-written
// exhaustion/wrap sequence, and randomized traffic against a queue model.
module tb_free_list;
    import free_list_pkg::*;

    localparam int N       = 3;
    localparam int FL_SIZE = 32;
    localparam int TAG_W   = 6;
    localparam int CNT_W   = 6;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic [N-1:0]            alloc_reqs = '0;
    logic [N-1:0][TAG_W-1:0] alloc_tags;
    logic                    alloc_stall;
    logic [CNT_W-1:0]        free_count;
    logic [N-1:0]            free_valids = '0;
    logic [N-1:0][TAG_W-1:0] free_tags = '0;
    logic                    mispredict = 1'b0;

    free_list #(.N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .alloc_reqs  (alloc_reqs),
        .alloc_tags  (alloc_tags),
        .alloc_stall (alloc_stall),
        .free_count  (free_count),
        .free_valids (free_valids),
        .free_tags   (free_tags),
        .mispredict  (mispredict)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: ordered queue of allocatable tags plus in-flight tags, oldest first.
    int free_q[$];
    int spec_q[$];

    logic                    got_stall;
    int                      got_cnt;
    logic [N-1:0][TAG_W-1:0] got_tags;

    typedef struct {
        logic [N-1:0] reqs;
        logic [N-1:0] fv;
        int           ft[N];
        logic         mp;
        int           exp_cnt;
        logic         exp_stall;
        int           exp_tag[N];
    } vec_t;

    vec_t vecs[$];

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic model_step(input logic [N-1:0] reqs, input logic [N-1:0] fv,
                              input logic [N-1:0][TAG_W-1:0] ft,
                              input logic mp, input logic rst);
        int a;
        int tmp[$];
        if (rst) begin
            free_q.delete();
            spec_q.delete();
            for (int e = 0; e < FL_SIZE; e++) free_q.push_back(32 + e);
            return;
        end
        a = $countones(reqs);
        if (!mp && a <= free_q.size()) begin
            for (int k = 0; k < a; k++) spec_q.push_back(free_q.pop_front());
        end
        for (int i = 0; i < N; i++)
            if (fv[i] && spec_q.size() > 0) void'(spec_q.pop_front());
        if (mp) begin
            tmp = spec_q;
            foreach (free_q[k]) tmp.push_back(free_q[k]);
            free_q = tmp;
            spec_q.delete();
        end
        for (int i = 0; i < N; i++)
            if (fv[i]) free_q.push_back(int'(ft[i]));
    endtask

    task automatic check_model(input logic [N-1:0] reqs);
        int a, k;
        logic exp_stall;
        a = $countones(reqs);
        exp_stall = (a > free_q.size());
        chk("rand_free_count", got_cnt, free_q.size());
        chk("rand_alloc_stall", int'(got_stall), int'(exp_stall));
        if (!exp_stall) begin
            k = 0;
            for (int i = 0; i < N; i++) begin
                if (reqs[i]) begin
                    chk($sformatf("rand_tag%0d", i), int'(got_tags[i]), free_q[k]);
                    k++;
                end
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] reqs, input logic [N-1:0] fv,
                         input logic [N-1:0][TAG_W-1:0] ft, input logic mp,
                         input logic rst, input bit use_model);
        alloc_reqs  = reqs;
        free_valids = fv;
        free_tags   = ft;
        mispredict  = mp;
        reset       = rst;
        @(negedge clock);
        got_stall = alloc_stall;
        got_cnt   = int'(free_count);
        got_tags  = alloc_tags;
        if (use_model && !rst) check_model(reqs);
        @(posedge clock);
        model_step(reqs, fv, ft, mp, rst);
        #1;
    endtask

    task automatic idle_reset();
        cycle('0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic add_vec(input logic [N-1:0] reqs, input logic [N-1:0] fv,
                           input int f0, input int f1, input int f2, input logic mp,
                           input int cnt, input logic stall,
                           input int t0, input int t1, input int t2);
        vec_t v;
        v.reqs = reqs; v.fv = fv; v.mp = mp;
        v.ft[0] = f0; v.ft[1] = f1; v.ft[2] = f2;
        v.exp_cnt = cnt; v.exp_stall = stall;
        v.exp_tag[0] = t0; v.exp_tag[1] = t1; v.exp_tag[2] = t2;
        vecs.push_back(v);
    endtask

    initial begin
        logic [N-1:0][TAG_W-1:0] ft;
        logic [N-1:0]            fv, rq;
        int                      avail;

        // Reset, compaction, and mispredict rollback (entry at arch_head 3 = 35).
        add_vec(3'b111, 3'b000, 0, 0, 0, 1'b1, 32, 1'b0, 32, 33, 34);
        add_vec(3'b101, 3'b000, 0, 0, 0, 1'b0, 32, 1'b0, 32, -1, 33);
        add_vec(3'b111, 3'b000, 0, 0, 0, 1'b0, 30, 1'b0, 34, 35, 36);
        add_vec(3'b011, 3'b011, 3, 7, 0, 1'b0, 27, 1'b0, 37, 38, -1);
        add_vec(3'b111, 3'b001, 9, 0, 0, 1'b1, 27, 1'b0, 39, 40, 41);
        add_vec(3'b001, 3'b000, 0, 0, 0, 1'b0, 32, 1'b0, 35, -1, -1);
        add_vec(3'b110, 3'b000, 0, 0, 0, 1'b0, 31, 1'b0, -1, 36, 37);
        add_vec(3'b000, 3'b000, 0, 0, 0, 1'b0, 29, 1'b0, -1, -1, -1);

        idle_reset();
        foreach (vecs[v]) begin
            for (int i = 0; i < N; i++) ft[i] = TAG_W'(vecs[v].ft[i]);
            cycle(vecs[v].reqs, vecs[v].fv, ft, vecs[v].mp, 1'b0, 1'b0);
            chk($sformatf("vec%0d_free_count", v), got_cnt, vecs[v].exp_cnt);
            chk($sformatf("vec%0d_alloc_stall", v), int'(got_stall), int'(vecs[v].exp_stall));
            if (!vecs[v].exp_stall)
                for (int i = 0; i < N; i++)
                    if (vecs[v].reqs[i])
                        chk($sformatf("vec%0d_tag%0d", v, i), int'(got_tags[i]), vecs[v].exp_tag[i]);
        end

        // Exhaustion, exact grant to zero, then recycle with pointer wrap.
        idle_reset();
        for (int c = 0; c < 10; c++) cycle(3'b111, '0, '0, 1'b0, 1'b0, 1'b0);
        cycle(3'b001, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("exh_count2", got_cnt, 2);
        chk("exh_tag62", int'(got_tags[0]), 62);
        cycle(3'b011, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("exh_stall_req2", int'(got_stall), 1);
        chk("exh_count1", got_cnt, 1);
        cycle(3'b111, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("exh_stall_req3", int'(got_stall), 1);
        chk("exh_head_held", got_cnt, 1);
        cycle(3'b001, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("exh_exact_stall", int'(got_stall), 0);
        chk("exh_tag63", int'(got_tags[0]), 63);
        cycle(3'b100, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("exh_count0", got_cnt, 0);
        chk("exh_stall_empty", int'(got_stall), 1);
        ft = '0; ft[0] = TAG_W'(5);
        cycle(3'b000, 3'b001, ft, 1'b0, 1'b0, 1'b0);
        chk("wrap_count0_noreq", got_cnt, 0);
        chk("wrap_nostall_noreq", int'(got_stall), 0);
        cycle(3'b010, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("wrap_count1", got_cnt, 1);
        chk("wrap_stall", int'(got_stall), 0);
        chk("wrap_tag5", int'(got_tags[1]), 5);
        cycle(3'b000, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("wrap_count_after", got_cnt, 0);

        // Randomized traffic against the queue model.
        idle_reset();
        for (int c = 0; c < 800; c++) begin
            rq = N'($urandom);
            fv = '0;
            avail = spec_q.size();
            for (int i = 0; i < N; i++) begin
                ft[i] = TAG_W'($urandom_range(0, 63));
                if ($urandom_range(0, 1) == 1 && avail > 0) begin
                    fv[i] = 1'b1;
                    avail--;
                end
            end
            cycle(rq, fv, ft, ($urandom_range(0, 19) == 0), 1'b0, 1'b1);
        end

        // Reset wins over everything else active in the same cycle.
        ft = '0; ft[0] = TAG_W'(1); ft[1] = TAG_W'(2); ft[2] = TAG_W'(3);
        cycle(3'b111, 3'b111, ft, 1'b1, 1'b1, 1'b0);
        cycle(3'b111, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_count", got_cnt, 32);
        chk("rst_mid_stall", int'(got_stall), 0);
        for (int i = 0; i < N; i++)
            chk($sformatf("rst_mid_tag%0d", i), int'(got_tags[i]), 32 + i);
        cycle(3'b101, '0, '0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/free_list.md
# free_list

Circular buffer of free physical register tags for the rename stage. It sits directly upstream of `map_table`: each cycle it hands up to `N` free `PHYS_TAG`s to dispatch, and those tags become `map_table.write_phys_regs`. Retirement returns superseded tags to the tail. A mispredict rolls the allocation head back to the retirement-committed head in a single cycle.

## Interface
Parameters:
- `N`, default `` `N ``: superscalar width (dispatch and retire slots).
- `PHYS_REGS`, default 64: number of physical registers.
- `ARCH_REGS`, default 32: number of architectural registers.
- `FL_SIZE`, default `PHYS_REGS-ARCH_REGS` (32): number of free-list entries.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `alloc_reqs`  in  `N`  slot i wants a destination tag this cycle.
- `alloc_tags`  out  `PHYS_TAG[N]`  tag for slot i; meaningful only where `alloc_reqs[i]`=1.
- `alloc_stall`  out  1  popcount(`alloc_reqs`) > `free_count`; nothing is allocated this cycle.
- `free_count`  out  `$clog2(FL_SIZE+1)`  number of entries currently free (registered).
- `free_valids`  in  `N`  retire slot i frees a tag.
- `free_tags`  in  `PHYS_TAG[N]`  superseded tag being freed by retire slot i.
- `mispredict`  in  1  squash all speculative allocations.

## Operation
State:
- `entries[FL_SIZE]` of `PHYS_TAG`.
- `head`, `tail`, `arch_head`: `$clog2(FL_SIZE)`-bit pointers, all wrapping modulo `FL_SIZE`.
- `count`.

Reset:
- `entries[i]` = `ARCH_REGS+i`.
- `head` = `tail` = `arch_head` = 0.
- `count` = `FL_SIZE`.

Allocation (combinational):
- Slot i receives `entries[head + k_i]`, where k_i is the number of requesting slots below i. Requesting slots are compacted, so non-requesting slots consume no entry.
- Index arithmetic wraps.

Allocation commit:
- If not `alloc_stall` and not `mispredict`, `head += A`, where A = popcount(`alloc_reqs`).
- If `alloc_stall`, the whole group is rejected: no partial grants and no pointer movement.

Free:
- Free slots are compacted in index order.
- `entries[tail + j_i] <= free_tags[i]`, then `tail += F`, where F = popcount(`free_valids`).
- Each retiring tag also advances `arch_head += F`. Every retiring instruction with a destination frees exactly one old tag, so `tail - arch_head` stays `FL_SIZE`.

Count:
- `count_next = count - (granted ? A : 0) + F`.
- Tags freed this cycle are not allocatable until the next cycle.

Mispredict:
- `head <= arch_head + F`, i.e. including retires in the same cycle.
- `count <= FL_SIZE`.
- Allocation requests in the same cycle are ignored.
- Frees in the same cycle still write entries and advance `tail` and `arch_head`.

Boundaries:
- A == `free_count` is granted exactly, leaving `free_count` at 0.
- `free_count` 0 with any request asserts stall.
- A free while `count == FL_SIZE` is a protocol violation: simulation assertion, behaviour undefined.
- Wrap-around of all three pointers is seamless.
- Reset wins over mispredict, alloc and free.

## Timing
- `alloc_tags` and `alloc_stall` are combinational from registered `head`/`count` and `alloc_reqs`: zero-cycle lookup.
- Pointer, count and entry updates become visible one cycle after the posedge.
- Freed tags are allocatable starting the cycle after the free.
- After reset, `free_count`=32 and `alloc_stall`=0. With all requests set, `alloc_tags[i]` = 32+i.
- Mispredict recovery is one cycle: the next cycle sees `free_count`=`FL_SIZE`.

## Structure
- `PHYS_TAG`, `PHYS_REGS`, `ARCH_REGS` and `FL_SIZE` belong in `sys_defs.svh`, shared with `map_table`.
- One natural sub-module: `prefix_count`, a combinational N-bit exclusive prefix popcount. It is instantiated twice, once for allocation compaction and once for free compaction.

## Test plan
- **Reset:** reset, then `alloc_reqs`=all ones → `alloc_tags`={32,33,…,32+N-1}, `free_count`=32, `alloc_stall`=0.
- **Compaction:** `alloc_reqs`=0b101 (N=3) → slot0=32, slot2=33. Next cycle `free_count`=30 and slot0 offers 34.
- **Exhaustion:** allocate until `free_count`=1, then request 2 → `alloc_stall`=1, `head` unchanged. Request 1 → tag 63, `free_count`=0.
- **Recycle and wrap:** free tag 5 in a cycle with `free_count`=0 → next cycle `free_count`=1 and the allocated tag is 5 (pointer wrapped from 31 to 0).
- **Mispredict:** after 7 allocations and 2 retires (frees of 3 and 7), assert `mispredict` with 1 retire (free 9) and a request → request ignored. Next cycle `free_count`=32, and the next allocated tag is the entry at `arch_head`=3.
- **Reset mid-operation:** reset with requests, frees and mispredict all active → identical state to the first scenario.
